// File: rtl/cpu_reg_arbiter_if.sv
// Requester-side and register-port signals of the CPU register arbiter.
// Handshake: a requester holds req[i] and its fields until it sees gnt[i]; gnt and done are one-cycle pulses.
interface cpu_reg_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic [1:0]    req;
  logic [1:0]    req_rw;
  logic [AW-1:0] req_addr0;
  logic [AW-1:0] req_addr1;
  logic [DW-1:0] req_wdata0;
  logic [DW-1:0] req_wdata1;
  logic [1:0]    gnt;
  logic [1:0]    done;
  logic [DW-1:0] rdata;
  logic          busy;
  logic [AW-1:0] bus_addr;
  logic          bus_rw;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;

  modport master (
    output req, req_rw, req_addr0, req_addr1, req_wdata0, req_wdata1, bus_rdata,
    input  gnt, done, rdata, busy, bus_addr, bus_rw, bus_wdata
  );

  modport slave (
    input  req, req_rw, req_addr0, req_addr1, req_wdata0, req_wdata1, bus_rdata,
    output gnt, done, rdata, busy, bus_addr, bus_rw, bus_wdata
  );
endinterface

// File: rtl/cpu_reg_arbiter.sv
// Round-robin arbiter sharing one CPU register port between two single-transaction requesters.
// All port-side outputs are registered; read data returns after RD_LAT cycles of wait.
module cpu_reg_arbiter #(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  cpu_reg_arbiter_if.slave bus,
  output logic [1:0]       dbg_state_o
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_e;

  localparam int CW = 3;

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    done_q, done_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rw_q, rw_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          win;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt_d   = 2'b00;
    done_d  = 2'b00;
    addr_d  = addr_q;
    rw_d    = 1'b0;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    win     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          // Contention goes to the pointer; a lone requester always wins.
          win        = (bus.req == 2'b11) ? ptr_q : bus.req[1];
          gnt_d[win] = 1'b1;
          owner_d    = win;
          ptr_d      = ~win;
          addr_d     = win ? bus.req_addr1 : bus.req_addr0;
          wdata_d    = win ? bus.req_wdata1 : bus.req_wdata0;
          rw_d       = bus.req_rw[win];
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (rw_q) begin
          done_d[owner_q] = 1'b1;
          state_d         = IDLE;
        end else begin
          cnt_d   = CW'(RD_LAT);
          state_d = RDWAIT;
        end
      end
      RDWAIT: begin
        if (cnt_q == CW'(1)) begin
          rdata_d         = bus.bus_rdata;
          done_d[owner_q] = 1'b1;
          state_d         = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.bus_addr  = addr_q;
  assign bus.bus_rw    = rw_q;
  assign bus.bus_wdata = wdata_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_cpu_reg_arbiter.sv
// Bench for cpu_reg_arbiter: RD_LAT=1 instance checked by a scoreboard monitor,
// RD_LAT=3 instance used for long-read latency and mid-transaction reset.
module tb_cpu_reg_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic rst3_n = 1'b0;
  int   cyc    = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cpu_reg_arbiter_if #(.AW(AW), .DW(DW)) bif1 ();
  cpu_reg_arbiter_if #(.AW(AW), .DW(DW)) bif3 ();
  logic [1:0] dbg1;
  logic [1:0] dbg3;

  cpu_reg_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bif1.slave), .dbg_state_o(dbg1)
  );
  cpu_reg_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .bus(bif3.slave), .dbg_state_o(dbg3)
  );

  // Register-file models: 1-cycle and 3-cycle read pipelines.
  logic [DW-1:0] mem1 [256];
  logic [DW-1:0] mem3 [256];
  logic [DW-1:0] dout1;
  logic [DW-1:0] pipe3 [3];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) begin
        mem1[i] <= '0;
        mem3[i] <= '0;
      end
    end else begin
      if (bif1.bus_rw) mem1[bif1.bus_addr] <= bif1.bus_wdata;
      if (bif3.bus_rw) mem3[bif3.bus_addr] <= bif3.bus_wdata;
    end
    dout1    <= mem1[bif1.bus_addr];
    pipe3[0] <= mem3[bif3.bus_addr];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign bif1.bus_rdata = dout1;
  assign bif3.bus_rdata = pipe3[2];

  // ---------------- scoreboard ----------------
  logic [1:0]       gnt_exp_q [$];
  int               gnt_cyc_q [$];
  logic [1:0]       done_exp_q[$];
  int               done_cyc_q[$];
  logic [DW:0]      done_rd_q [$];
  logic [AW+DW-1:0] wr_exp_q  [$];
  int               wr_cyc_q  [$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic void exp_gnt(input logic [1:0] b, input int c);
    gnt_exp_q.push_back(b);
    gnt_cyc_q.push_back(c);
  endfunction

  function automatic void exp_done(input logic [1:0] b, input int c, input logic rd, input logic [DW-1:0] d);
    done_exp_q.push_back(b);
    done_cyc_q.push_back(c);
    done_rd_q.push_back({rd, d});
  endfunction

  function automatic void exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input int c);
    wr_exp_q.push_back({a, d});
    wr_cyc_q.push_back(c);
  endfunction

  always @(negedge clk) begin
    logic [DW:0]      rd_e;
    logic [AW+DW-1:0] wr_e;
    if (rst_n) begin
      if (bif1.gnt != 2'b00) begin
        if (gnt_exp_q.size() == 0) check("gnt_unexpected", 32'(bif1.gnt), 0);
        else begin
          check("gnt_bits", 32'(bif1.gnt), 32'(gnt_exp_q.pop_front()));
          check("gnt_cycle", cyc, gnt_cyc_q.pop_front());
        end
      end
      if (bif1.done != 2'b00) begin
        if (done_exp_q.size() == 0) check("done_unexpected", 32'(bif1.done), 0);
        else begin
          check("done_bits", 32'(bif1.done), 32'(done_exp_q.pop_front()));
          check("done_cycle", cyc, done_cyc_q.pop_front());
          rd_e = done_rd_q.pop_front();
          if (rd_e[DW]) check("rdata", 32'(bif1.rdata), 32'(rd_e[DW-1:0]));
        end
      end
      if (bif1.bus_rw) begin
        if (wr_exp_q.size() == 0) check("bus_write_unexpected", 32'(bif1.bus_rw), 0);
        else begin
          wr_e = wr_exp_q.pop_front();
          check("bus_addr", 32'(bif1.bus_addr), 32'(wr_e[AW+DW-1:DW]));
          check("bus_wdata", 32'(bif1.bus_wdata), 32'(wr_e[DW-1:0]));
          check("bus_write_cycle", cyc, wr_cyc_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive1(input logic [1:0] r, input logic [1:0] rw,
                        input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic [AW-1:0] a1, input logic [DW-1:0] d1, output int c);
    @(negedge clk);
    bif1.req_rw     = rw;
    bif1.req_addr0  = a0;
    bif1.req_wdata0 = d0;
    bif1.req_addr1  = a1;
    bif1.req_wdata1 = d1;
    bif1.req        = r;
    c = cyc;
  endtask

  // Drops each request bit in the cycle its grant is seen, then lets the arbiter drain.
  task automatic serve1(input int budget);
    int n;
    n = 0;
    while (bif1.req != 2'b00 && n < budget) begin
      @(negedge clk);
      bif1.req = bif1.req & ~bif1.gnt;
      n++;
    end
    if (bif1.req != 2'b00) begin
      check("serve_timeout", 32'(bif1.req), 0);
      bif1.req = 2'b00;
    end
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int c;
    int ng;
    int busy_n;
    int done_k;
    int wr_seen;
    int done_n;
    logic [DW-1:0] rd;

    bif1.req = 2'b00; bif1.req_rw = 2'b00;
    bif1.req_addr0 = '0; bif1.req_addr1 = '0; bif1.req_wdata0 = '0; bif1.req_wdata1 = '0;
    bif3.req = 2'b00; bif3.req_rw = 2'b00;
    bif3.req_addr0 = '0; bif3.req_addr1 = '0; bif3.req_wdata0 = '0; bif3.req_wdata1 = '0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    rst3_n = 1'b1;
    @(negedge clk);

    check("rst_gnt", 32'(bif1.gnt), 0);
    check("rst_done", 32'(bif1.done), 0);
    check("rst_busy", 32'(bif1.busy), 0);
    check("rst_bus_addr", 32'(bif1.bus_addr), 0);
    check("rst_bus_rw", 32'(bif1.bus_rw), 0);
    check("rst_bus_wdata", 32'(bif1.bus_wdata), 0);
    check("rst_rdata", 32'(bif1.rdata), 0);
    check("rst_state", 32'(dbg1), 0);

    // Requester 0 writes 0xA5 to 0x10.
    drive1(2'b01, 2'b01, 8'h10, 8'hA5, 8'h00, 8'h00, c);
    exp_gnt(2'b01, c + 1);
    exp_wr(8'h10, 8'hA5, c + 1);
    exp_done(2'b01, c + 2, 1'b0, 8'h00);
    serve1(10);
    check("idle_hold_addr", 32'(bif1.bus_addr), 32'h10);
    check("idle_hold_wdata", 32'(bif1.bus_wdata), 32'hA5);

    // Requester 1 reads 0x10 back.
    drive1(2'b10, 2'b00, 8'h00, 8'h00, 8'h10, 8'h00, c);
    exp_gnt(2'b10, c + 1);
    exp_done(2'b10, c + 3, 1'b1, 8'hA5);
    serve1(10);

    // Both held: grants alternate 0,1,0,1 (pointer is back at 0).
    drive1(2'b11, 2'b11, 8'h20, 8'h11, 8'h21, 8'h22, c);
    exp_gnt(2'b01, c + 1); exp_wr(8'h20, 8'h11, c + 1); exp_done(2'b01, c + 2, 1'b0, 8'h00);
    exp_gnt(2'b10, c + 3); exp_wr(8'h21, 8'h22, c + 3); exp_done(2'b10, c + 4, 1'b0, 8'h00);
    exp_gnt(2'b01, c + 5); exp_wr(8'h20, 8'h11, c + 5); exp_done(2'b01, c + 6, 1'b0, 8'h00);
    exp_gnt(2'b10, c + 7); exp_wr(8'h21, 8'h22, c + 7); exp_done(2'b10, c + 8, 1'b0, 8'h00);
    ng = 0;
    for (int k = 0; k < 20 && ng < 4; k++) begin
      @(negedge clk);
      if (bif1.gnt != 2'b00) ng++;
    end
    bif1.req = 2'b00;
    check("alt_grant_count", ng, 4);
    repeat (4) @(negedge clk);

    // Requester 1 reads 0x21; requester 0 raises and withdraws a write while busy.
    drive1(2'b10, 2'b01, 8'h30, 8'h77, 8'h21, 8'h00, c);
    exp_gnt(2'b10, c + 1);
    exp_done(2'b10, c + 3, 1'b1, 8'h22);
    @(negedge clk);
    bif1.req = 2'b01;
    @(negedge clk);
    bif1.req = 2'b00;
    repeat (6) @(negedge clk);

    // Contending reads: pointer is at 0, so requester 0 first, 3-cycle grant spacing.
    drive1(2'b11, 2'b00, 8'h10, 8'h00, 8'h20, 8'h00, c);
    exp_gnt(2'b01, c + 1); exp_done(2'b01, c + 3, 1'b1, 8'hA5);
    exp_gnt(2'b10, c + 4); exp_done(2'b10, c + 6, 1'b1, 8'h11);
    serve1(20);

    // ---- RD_LAT = 3 instance ----
    @(negedge clk);
    bif3.req_rw = 2'b01; bif3.req_addr0 = 8'h22; bif3.req_wdata0 = 8'h5C; bif3.req = 2'b01;
    @(negedge clk);
    check("l3_wr_gnt", 32'(bif3.gnt), 32'h1);
    bif3.req = 2'b00;
    repeat (4) @(negedge clk);

    @(negedge clk);
    bif3.req_rw = 2'b00; bif3.req_addr1 = 8'h22; bif3.req = 2'b10;
    busy_n = 0; done_k = 0; wr_seen = 0; rd = '0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (bif3.gnt[1]) bif3.req = 2'b00;
      if (bif3.busy) busy_n++;
      if (bif3.bus_rw) wr_seen++;
      if (bif3.done[1] && done_k == 0) begin
        done_k = k;
        rd = bif3.rdata;
      end
    end
    check("l3_done_latency", done_k, 5);
    check("l3_busy_cycles", busy_n, 4);
    check("l3_rdata", 32'(rd), 32'h5C);
    check("l3_read_bus_rw", wr_seen, 0);

    // Reset pulse while the read is waiting.
    @(negedge clk);
    bif3.req = 2'b10;
    @(negedge clk);
    bif3.req = 2'b00;
    @(negedge clk);
    check("l3_in_rdwait", 32'(dbg3), 32'h2);
    @(posedge clk);
    #2 rst3_n = 1'b0;
    #1;
    check("l3_rst_busy", 32'(bif3.busy), 0);
    check("l3_rst_state", 32'(dbg3), 0);
    check("l3_rst_bus_addr", 32'(bif3.bus_addr), 0);
    check("l3_rst_bus_wdata", 32'(bif3.bus_wdata), 0);
    check("l3_rst_rdata", 32'(bif3.rdata), 0);
    check("l3_rst_gnt_done", 32'({bif3.gnt, bif3.done}), 0);
    @(negedge clk);
    rst3_n = 1'b1;
    done_n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bif3.done != 2'b00) done_n++;
    end
    check("l3_no_done_after_rst", done_n, 0);

    @(negedge clk);
    bif3.req_rw = 2'b11; bif3.req_addr0 = 8'h40; bif3.req_addr1 = 8'h41; bif3.req = 2'b11;
    @(negedge clk);
    check("l3_first_gnt_after_rst", 32'(bif3.gnt), 32'h1);
    check("l3_first_addr_after_rst", 32'(bif3.bus_addr), 32'h40);
    bif3.req = 2'b00;
    repeat (4) @(negedge clk);

    check("sb_gnt_left", gnt_exp_q.size(), 0);
    check("sb_done_left", done_exp_q.size(), 0);
    check("sb_wr_left", wr_exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
